// File: rtl/univ_shift_reg_param_amisha.sv
// Parametrised universal shift register.
// Each enabled rising edge applies one operation in a single cycle through a
// barrel structure: hold, logical shift left/right with serial fill, parallel
// load, arithmetic shift right, rotate left/right, or clear.
//
// Ports:
//   clk_amisha    - clock, all state updates on the rising edge
//   reset_amisha  - synchronous active-high reset (beats enable and ctrl)
//   en_amisha     - clock enable; 0 holds q, sout and zero
//   ctrl_amisha   - operation select (3 bits)
//   shamt_amisha  - shift/rotate amount k, 0..WIDTH-1
//   sin_amisha    - serial fill bit for logical shifts
//   d_amisha      - parallel load data
//   q_amisha      - register contents
//   sout_amisha   - last bit shifted or rotated out (registered)
//   zero_amisha   - high when q_amisha is zero (registered with q_amisha)
module univ_shift_reg_param_amisha #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_amisha,
  input  logic                     reset_amisha,
  input  logic                     en_amisha,
  input  logic [2:0]               ctrl_amisha,
  input  logic [$clog2(WIDTH)-1:0] shamt_amisha,
  input  logic                     sin_amisha,
  input  logic [WIDTH-1:0]         d_amisha,
  output logic [WIDTH-1:0]         q_amisha,
  output logic                     sout_amisha,
  output logic                     zero_amisha
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OpHold = 3'b000;
  localparam logic [2:0] OpShl  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpLoad = 3'b011;
  localparam logic [2:0] OpSar  = 3'b100;
  localparam logic [2:0] OpRol  = 3'b101;
  localparam logic [2:0] OpRor  = 3'b110;
  localparam logic [2:0] OpClr  = 3'b111;

  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] lo_mask;   // low k bits set
  logic [WIDTH-1:0] hi_mask;   // high k bits set
  logic [SHW-1:0]   idx_left;  // WIDTH-k, valid for k != 0
  logic [SHW-1:0]   idx_right; // k-1, valid for k != 0
  logic             k_nonzero;

  always_comb begin
    ones      = '1;
    lo_mask   = ~(ones << shamt_amisha);
    hi_mask   = ~(ones >> shamt_amisha);
    // WIDTH is a power of two, so WIDTH-k wraps cleanly in SHW bits
    idx_left  = SHW'(WIDTH) - shamt_amisha;
    idx_right = shamt_amisha - SHW'(1);
    k_nonzero = (shamt_amisha != '0);

    q_next    = q_amisha;
    sout_next = sout_amisha;

    case (ctrl_amisha)
      OpHold: ;
      OpShl: if (k_nonzero) begin
        q_next    = (q_amisha << shamt_amisha) | ({WIDTH{sin_amisha}} & lo_mask);
        sout_next = q_amisha[idx_left];
      end
      OpShr: if (k_nonzero) begin
        q_next    = (q_amisha >> shamt_amisha) | ({WIDTH{sin_amisha}} & hi_mask);
        sout_next = q_amisha[idx_right];
      end
      OpLoad: q_next = d_amisha;
      OpSar: if (k_nonzero) begin
        q_next    = (q_amisha >> shamt_amisha) | ({WIDTH{q_amisha[WIDTH-1]}} & hi_mask);
        sout_next = q_amisha[idx_right];
      end
      OpRol: if (k_nonzero) begin
        q_next    = (q_amisha << shamt_amisha) | (q_amisha >> idx_left);
        sout_next = q_amisha[idx_left];
      end
      OpRor: if (k_nonzero) begin
        q_next    = (q_amisha >> shamt_amisha) | (q_amisha << idx_left);
        sout_next = q_amisha[idx_right];
      end
      OpClr: begin
        q_next    = '0;
        sout_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      q_amisha    <= '0;
      sout_amisha <= 1'b0;
      zero_amisha <= 1'b1;
    end else if (en_amisha) begin
      q_amisha    <= q_next;
      sout_amisha <= sout_next;
      // Flag derived from the next value so it never lags q
      zero_amisha <= (q_next == '0);
    end
  end

endmodule

// File: tb/tb_univ_shift_reg_param_amisha.sv
// Bench for univ_shift_reg_param_amisha: runs an 8-bit and a 16-bit instance
// side by side against a bit-level reference model, with directed cases
// followed by random operations.
module tb_univ_shift_reg_param_amisha;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  ctrl;
  logic [3:0]  shamt;
  logic        sin;
  logic [15:0] d;

  logic [7:0]  q8;
  logic        sout8, zero8;
  logic [15:0] q16;
  logic        sout16, zero16;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per width (index 0: 8-bit, 1: 16-bit)
  logic [15:0] mq[2];
  logic        ms[2];
  logic        mz[2];

  always #5 clk = ~clk;

  univ_shift_reg_param_amisha #(.WIDTH(8)) u_dut8 (
    .clk_amisha   (clk),
    .reset_amisha (rst),
    .en_amisha    (en),
    .ctrl_amisha  (ctrl),
    .shamt_amisha (shamt[2:0]),
    .sin_amisha   (sin),
    .d_amisha     (d[7:0]),
    .q_amisha     (q8),
    .sout_amisha  (sout8),
    .zero_amisha  (zero8)
  );

  univ_shift_reg_param_amisha #(.WIDTH(16)) u_dut16 (
    .clk_amisha   (clk),
    .reset_amisha (rst),
    .en_amisha    (en),
    .ctrl_amisha  (ctrl),
    .shamt_amisha (shamt),
    .sin_amisha   (sin),
    .d_amisha     (d),
    .q_amisha     (q16),
    .sout_amisha  (sout16),
    .zero_amisha  (zero16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-position model: returns {zero, sout, q} after one edge
  function automatic logic [17:0] model(input int w, input logic [15:0] q, input logic s,
                                        input logic z, input logic r, input logic e,
                                        input logic [2:0] c, input int k, input logic fill,
                                        input logic [15:0] dd);
    logic [15:0] nq;
    logic        ns;
    nq = q;
    ns = s;
    if (r) return {1'b1, 1'b0, 16'h0};
    if (!e) return {z, s, q};
    case (c)
      3'd1: if (k != 0) begin
        for (int i = 0; i < w; i++) nq[i] = (i >= k) ? q[i-k] : fill;
        ns = q[w-k];
      end
      3'd2: if (k != 0) begin
        for (int i = 0; i < w; i++) nq[i] = (i + k < w) ? q[i+k] : fill;
        ns = q[k-1];
      end
      3'd3: begin
        nq = 16'h0;
        for (int i = 0; i < w; i++) nq[i] = dd[i];
      end
      3'd4: if (k != 0) begin
        for (int i = 0; i < w; i++) nq[i] = (i + k < w) ? q[i+k] : q[w-1];
        ns = q[k-1];
      end
      3'd5: if (k != 0) begin
        for (int i = 0; i < w; i++) nq[i] = q[(i - k + w) % w];
        ns = q[w-k];
      end
      3'd6: if (k != 0) begin
        for (int i = 0; i < w; i++) nq[i] = q[(i + k) % w];
        ns = q[k-1];
      end
      3'd7: begin
        nq = 16'h0;
        ns = 1'b0;
      end
      default: ;
    endcase
    return {(nq == 16'h0), ns, nq};
  endfunction

  task automatic step(input logic r, input logic e, input logic [2:0] c, input logic [3:0] k,
                      input logic fill, input logic [15:0] dd);
    logic [17:0] res;
    rst   = r;
    en    = e;
    ctrl  = c;
    shamt = k;
    sin   = fill;
    d     = dd;
    @(posedge clk);
    #1;
    res = model(8, mq[0], ms[0], mz[0], r, e, c, int'(k[2:0]), fill, dd & 16'h00ff);
    {mz[0], ms[0], mq[0]} = res;
    res = model(16, mq[1], ms[1], mz[1], r, e, c, int'(k), fill, dd);
    {mz[1], ms[1], mq[1]} = res;
    check("q8_model", {24'h0, q8}, {16'h0, mq[0]});
    check("sout8_model", {31'h0, sout8}, {31'h0, ms[0]});
    check("zero8_model", {31'h0, zero8}, {31'h0, mz[0]});
    check("q16_model", {16'h0, q16}, {16'h0, mq[1]});
    check("sout16_model", {31'h0, sout16}, {31'h0, ms[1]});
    check("zero16_model", {31'h0, zero16}, {31'h0, mz[1]});
  endtask

  initial begin
    mq[0] = 16'h0; ms[0] = 1'b0; mz[0] = 1'b1;
    mq[1] = 16'h0; ms[1] = 1'b0; mz[1] = 1'b1;
    rst = 1'b1; en = 1'b0; ctrl = 3'd0; shamt = 4'd0; sin = 1'b0; d = 16'h0;

    // Reset and first load
    step(1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 16'h00ff);
    check("rst_q", {24'h0, q8}, 32'h00);
    check("rst_sout", {31'h0, sout8}, 32'h0);
    check("rst_zero", {31'h0, zero8}, 32'h1);
    step(1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 16'h00d3);
    check("load_q", {24'h0, q8}, 32'hd3);
    check("load_zero", {31'h0, zero8}, 32'h0);

    // Logical shifts
    step(1'b0, 1'b1, 3'd1, 4'd1, 1'b0, 16'h0);
    check("shl_q", {24'h0, q8}, 32'ha6);
    check("shl_sout", {31'h0, sout8}, 32'h1);
    step(1'b0, 1'b1, 3'd2, 4'd1, 1'b1, 16'h0);
    check("shr_q", {24'h0, q8}, 32'hd3);
    check("shr_sout", {31'h0, sout8}, 32'h0);

    // Arithmetic shift and rotates
    step(1'b0, 1'b1, 3'd4, 4'd3, 1'b0, 16'h0);
    check("sar_q", {24'h0, q8}, 32'hfa);
    check("sar_sout", {31'h0, sout8}, 32'h0);
    step(1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 16'h00d3);
    step(1'b0, 1'b1, 3'd5, 4'd4, 1'b0, 16'h0);
    check("rol_q", {24'h0, q8}, 32'h3d);
    check("rol_sout", {31'h0, sout8}, 32'h1);
    step(1'b0, 1'b1, 3'd6, 4'd1, 1'b0, 16'h0);
    check("ror_q", {24'h0, q8}, 32'h9e);
    check("ror_sout", {31'h0, sout8}, 32'h1);

    // Holds and clear
    step(1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 16'h0055);
    check("en0_q", {24'h0, q8}, 32'h9e);
    check("en0_sout", {31'h0, sout8}, 32'h1);
    step(1'b0, 1'b1, 3'd1, 4'd0, 1'b1, 16'h0);
    check("k0_q", {24'h0, q8}, 32'h9e);
    check("k0_sout", {31'h0, sout8}, 32'h1);
    step(1'b0, 1'b1, 3'd7, 4'd0, 1'b0, 16'h0);
    check("clr_q", {24'h0, q8}, 32'h00);
    check("clr_sout", {31'h0, sout8}, 32'h0);
    check("clr_zero", {31'h0, zero8}, 32'h1);

    // Shift to zero, then reset beats a load
    step(1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 16'h000f);
    step(1'b0, 1'b1, 3'd2, 4'd4, 1'b0, 16'h0);
    check("shr0_q", {24'h0, q8}, 32'h00);
    check("shr0_zero", {31'h0, zero8}, 32'h1);
    check("shr0_sout", {31'h0, sout8}, 32'h1);
    step(1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 16'h00ff);
    step(1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 16'h00ff);
    check("rstld_q", {24'h0, q8}, 32'h00);

    // 16-bit instance boundary amounts
    step(1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 16'h8001);
    step(1'b0, 1'b1, 3'd5, 4'd15, 1'b0, 16'h0);
    check("w16_rol_q", {16'h0, q16}, 32'hc000);
    check("w16_rol_sout", {31'h0, sout16}, 32'h0);
    step(1'b0, 1'b1, 3'd4, 4'd15, 1'b0, 16'h0);
    check("w16_sar_q", {16'h0, q16}, 32'hffff);
    step(1'b0, 1'b1, 3'd1, 4'd8, 1'b1, 16'h0);
    check("w16_shl_q", {16'h0, q16}, 32'hffff);
    check("w16_shl_sout", {31'h0, sout16}, 32'h1);

    // Random operations
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_param_amisha.md
Name: univ_shift_reg_param_amisha

Overview:
- Parametrised, next-generation universal shift register for the sequential-circuit library.
- Replaces the fixed 8-bit, 2-bit-control version. Adds:
  - configurable width
  - multi-bit shift amount in one cycle
  - arithmetic shift and rotates
  - serial fill input
  - registered shift-out and zero flag
  - clock enable
- Used as a datapath register for shifters, serialisers and ALU experiments.

Parameters:
- WIDTH, 8, register width in bits. Must be a power of 2 and at least 2.
- SHW, $clog2(WIDTH), shift-amount width. This is a derived localparam and cannot be overridden.

Ports:
- clk_amisha  in  1  clock. All state updates on its rising edge.
- reset_amisha  in  1  synchronous, active-high reset.
- en_amisha  in  1  clock enable. When 0, all state holds.
- ctrl_amisha  in  3  operation select (see Behaviour).
- shamt_amisha  in  SHW  shift/rotate amount k, range 0..WIDTH-1.
- sin_amisha  in  1  serial fill bit for logical shifts.
- d_amisha  in  WIDTH  parallel load data.
- q_amisha  out  WIDTH  register contents.
- sout_amisha  out  1  last bit shifted or rotated out (registered).
- zero_amisha  out  1  high when q_amisha == 0 (registered, consistent with q_amisha).

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: q_amisha = 0, sout_amisha = 0, zero_amisha = 1. Reset has priority over en_amisha and ctrl_amisha.
- Latency: one edge. The result of the operation sampled at edge N is visible on q/sout/zero immediately after edge N.
- en_amisha = 0: q, sout and zero all hold regardless of ctrl.
- ctrl encoding (k = shamt_amisha; old 2-bit codes are preserved with MSB = 0):
  - 000 hold.
  - 001 logical shift left: q <= {q[W-1-k:0], k copies of sin}; sout <= q[W-k].
  - 010 logical shift right: q <= {k copies of sin, q[W-1:k]}; sout <= q[k-1].
  - 011 parallel load: q <= d. sout holds.
  - 100 arithmetic shift right: fill bits = old q[W-1]; sout <= q[k-1].
  - 101 rotate left by k: sout <= q[W-k] (the last bit to wrap).
  - 110 rotate right by k: sout <= q[k-1].
  - 111 clear: q <= 0, sout <= 0.
- k = 0 on any shift/rotate op (001, 010, 100, 101, 110): q and sout both hold. There is no out-of-range slice.
- zero_amisha <= (q_next == 0) on every enabled edge, so zero is never one cycle stale.
- Whole shift in one cycle: barrel structure only, no multi-cycle sequencing.
- Inputs are sampled only at the edge. Changing ctrl/d between edges has no effect.
- Reset asserted in the same cycle as any operation: the reset result wins and the operation is discarded.

Test Plan:
Default WIDTH = 8 unless noted.
1. Reset high 2 edges -> q = 00, sout = 0, zero = 1. Release reset, load d = D3 -> q = D3, zero = 0, sout = 0.
2. From q = D3, shl k=1, sin=0 -> q = A6, sout = 1. Then shr k=1, sin=1 -> q = D3, sout = 0.
3. From q = D3: sar k=3 -> q = FA, sout = 0. Reload D3, rol k=4 -> q = 3D, sout = 1. Then ror k=1 -> q = 9E, sout = 1.
4. Holds and clear:
   - en = 0 with ctrl = load, d = 55 -> q, sout, zero unchanged.
   - en = 1, shl with k = 0 -> q, sout unchanged.
   - clear -> q = 00, sout = 0, zero = 1 on the same edge.
5. q = 0F, shr k=4, sin=0 -> q = 00, zero = 1 on that edge, sout = 1. Reset asserted together with load d = FF -> q = 00.
6. WIDTH = 16 instance:
   - load 8001, rol k=15 -> q = C000, sout = 0.
   - sar k=15 -> q = FFFF.
   - shl k=8, sin=1 -> q = FFFF, sout = 1.
